reflet_periph_bridge: RTL and testbench

Parametrised bridge between a Reflet CPU word bus of any width (16/32/64) and the 8-bit peripheral bus. It decodes the peripheral window, steers byte lanes and, unlike plain lane steering, serialises wide (full-word) accesses into consecutive byte transactions. It honours a peripheral ready handshake and stalls the CPU through `cpu_enable` until the access completes. It sits between the CPU and `reflet_peripheral` in 16/32/64-bit controllers, and its `cpu_rdata` is ORed into the CPU read bus.

---
 rtl/reflet_periph_bridge.sv | 147 ++++++++++++++
 tb/tb_reflet_periph_bridge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_periph_bridge.sv
// Bridge from a Reflet CPU word bus to the 8-bit peripheral bus; full-word accesses are split into byte transactions.
// Optional build macro REFLET_BRIDGE_TIMEOUT_EN adds a p_ready timeout and the sticky err flag.
module reflet_periph_bridge #(
  parameter int wordsize = 16,
  parameter int periph_addr_size = 8,
  parameter logic [wordsize-periph_addr_size-1:0] base_addr = '1,
  parameter int timeout_cycles = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [wordsize-1:0]         cpu_addr,
  input  logic [wordsize-1:0]         cpu_wdata,
  input  logic                        cpu_write_en,
  input  logic                        cpu_wide,
  output logic [wordsize-1:0]         cpu_rdata,
  output logic                        cpu_enable,
  output logic [periph_addr_size-1:0] p_addr,
  output logic [7:0]                  p_wdata,
  output logic                        p_write_en,
  output logic                        p_strobe,
  input  logic [7:0]                  p_rdata,
  input  logic                        p_ready,
  output logic                        err,
  output logic [1:0]                  dbg_state
);

  localparam int lanes = wordsize / 8;
  localparam int lw = $clog2(lanes);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam bit params_ok = (wordsize % 8 == 0) && (wordsize >= 16) &&
                             (periph_addr_size > lw) && (periph_addr_size < wordsize) &&
                             (timeout_cycles >= 1) && (timeout_cycles <= 255);

  generate
    if (!params_ok) begin : g_bad_params
      $error("reflet_periph_bridge: unsupported parameter set");
    end
  endgenerate

  logic [1:0]                       state;
  logic [periph_addr_size-1:lw]     addr_hi;
  logic [lw-1:0]                    idx;
  logic [wordsize-1:0]              wdata_q;
  logic [wordsize-1:0]              rbuf;
  logic                             write_q;
  logic                             wide_q;
  logic                             first_q;
  logic                             hit;
  logic                             last_byte;
  logic                             byte_done;
  logic [7:0]                       byte_val;

  assign hit       = (state == IDLE) && (cpu_addr[wordsize-1:periph_addr_size] == base_addr);
  assign last_byte = !wide_q || (idx == lw'(lanes - 1));
  assign dbg_state = state;

  // Handshake: p_strobe marks the first cycle of a byte request; p_addr, p_wdata and
  // p_write_en stay stable until the first XFER cycle in which p_ready is high, which
  // completes that byte. p_ready in any other state is ignored.
  always_comb begin
    cpu_enable = !(hit || (state == XFER));
    p_strobe   = (state == XFER) && first_q;
    p_write_en = (state == XFER) && write_q;
    p_addr     = {addr_hi, idx};
    p_wdata    = 8'h00;
    for (int i = 0; i < lanes; i++) begin
      if (idx == lw'(i)) p_wdata = wdata_q[i*8 +: 8];
    end
    cpu_rdata  = ((state == DONE) && !write_q) ? rbuf : '0;
  end

`ifdef REFLET_BRIDGE_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       timed_out;
  logic       err_q;

  // tcnt is 0 in every strobe cycle, so a byte may occupy at most timeout_cycles XFER cycles.
  assign timed_out = (state == XFER) && !p_ready && (tcnt == 8'(timeout_cycles - 1));
  assign byte_done = (state == XFER) && (p_ready || timed_out);
  assign byte_val  = p_ready ? p_rdata : 8'hFF;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      tcnt  <= ((state == XFER) && !byte_done) ? tcnt + 8'd1 : 8'd0;
      err_q <= err_q | timed_out;
    end
  end
`else
  assign byte_done = (state == XFER) && p_ready;
  assign byte_val  = p_rdata;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_hi <= '0;
      idx     <= '0;
      wdata_q <= '0;
      rbuf    <= '0;
      write_q <= 1'b0;
      wide_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state   <= XFER;
            addr_hi <= cpu_addr[periph_addr_size-1:lw];
            // Wide accesses walk from the aligned base; narrow ones use the addressed lane.
            idx     <= cpu_wide ? '0 : cpu_addr[lw-1:0];
            wdata_q <= cpu_wdata;
            write_q <= cpu_write_en;
            wide_q  <= cpu_wide;
            first_q <= 1'b1;
            rbuf    <= '0;
          end
        end
        XFER: begin
          first_q <= 1'b0;
          if (byte_done) begin
            for (int i = 0; i < lanes; i++) begin
              if (idx == lw'(i)) rbuf[i*8 +: 8] <= byte_val;
            end
            if (last_byte) begin
              state <= DONE;
            end else begin
              idx     <= idx + 1'b1;
              first_q <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_periph_bridge.sv
// Self-checking bench for reflet_periph_bridge at wordsize 32: table vectors, corner sequences and random accesses vs. a reference model.
module tb_reflet_periph_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_write_en;
  logic        cpu_wide;
  logic [31:0] cpu_rdata;
  logic        cpu_enable;
  logic [7:0]  p_addr;
  logic [7:0]  p_wdata;
  logic        p_write_en;
  logic        p_strobe;
  logic [7:0]  p_rdata;
  logic        p_ready;
  logic        err;
  logic [1:0]  dbg_state;

  reflet_periph_bridge #(
    .wordsize(32),
    .periph_addr_size(8),
    .base_addr(24'hFFFFFF),
    .timeout_cycles(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_write_en(cpu_write_en), .cpu_wide(cpu_wide),
    .cpu_rdata(cpu_rdata), .cpu_enable(cpu_enable),
    .p_addr(p_addr), .p_wdata(p_wdata), .p_write_en(p_write_en), .p_strobe(p_strobe),
    .p_rdata(p_rdata), .p_ready(p_ready), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [16:0] exp_q[$];   // expected strobes: {write_en, p_addr, p_wdata}
  logic [7:0]  mem[256];   // peripheral read contents
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        wr;
    logic        wide;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] exp_rdata;
    int          exp_stall;
    int          exp_nstb;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: derives the strobe list, read word and stall length from the access itself.
  task automatic model_access(input logic wr, input logic wide, input logic [31:0] addr,
                              input logic [31:0] wdata, input int delay,
                              output logic [31:0] rdata, output int stall, output int nb);
    logic [7:0] a;
    int lane;
    rdata = 32'h0;
    stall = 0;
    nb    = 0;
    if (addr[31:8] != 24'hFFFFFF) return;
    nb = wide ? 4 : 1;
    for (int k = 0; k < nb; k++) begin
      lane = wide ? k : int'(addr % 4);
      a    = wide ? 8'((addr & 32'hFC) + 32'(k)) : addr[7:0];
      exp_q.push_back({wr, a, wr ? wdata[lane*8 +: 8] : 8'h00});
      if (!wr) rdata = rdata | (32'(mem[a]) << (8 * lane));
    end
    stall = 1 + nb * (1 + delay);
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cpu_addr = 32'h0000_1000;
    p_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one CPU access and plays the peripheral, answering each strobe after `delay` wait cycles.
  task automatic run_access(input logic wr, input logic wide, input logic [31:0] addr,
                            input logic [31:0] wdata, input int delay,
                            output logic [31:0] rdata, output int stall,
                            output int nstb, output int bad_rdata);
    int wait_cnt;
    bit pending;
    bit done;
    logic [16:0] e;
    @(negedge clk);
    cpu_addr = addr; cpu_wdata = wdata; cpu_write_en = wr; cpu_wide = wide; p_ready = 1'b0;
    rdata = 32'h0; stall = 0; nstb = 0; bad_rdata = 0;
    pending = 1'b0; wait_cnt = 0; done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      #1;
      if (p_strobe) begin
        nstb++;
        if (exp_q.size() == 0) begin
          check("strobe_unexpected", 64'(p_addr), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("strobe_we_addr", {p_write_en, p_addr}, 64'(e[16:8]));
          if (e[16]) check("strobe_wdata", p_wdata, 64'(e[7:0]));
        end
        pending = 1'b1;
        wait_cnt = delay;
      end
      if (pending) begin
        if (wait_cnt == 0) begin
          p_ready = 1'b1;
          p_rdata = mem[p_addr];
          pending = 1'b0;
        end else begin
          wait_cnt--;
          p_ready = 1'b0;
          p_rdata = 8'($urandom);
        end
      end else begin
        p_ready = 1'b0;
      end
      if (cpu_enable) begin
        rdata = cpu_rdata;
        done = 1'b1;
        cpu_addr = 32'h0000_1000;
      end else begin
        stall++;
        if (cpu_rdata !== 32'h0) bad_rdata++;
      end
      @(negedge clk);
    end
    p_ready = 1'b0;
    if (!done) check("access_cycle_budget", 0, 1);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] r, m_r;
    int s, n, b, m_s, m_n, lows, cnt;
    logic wr, wide, is_hit;
    logic [31:0] addr, wdata;
    int delay;

    tbl[0] = '{1'b0, 1'b0, 32'hFFFFFF13, 32'h0,        0, 32'hA5000000, 2, 1};
    tbl[1] = '{1'b1, 1'b1, 32'hFFFFFF22, 32'h11223344, 0, 32'h00000000, 5, 4};
    tbl[2] = '{1'b0, 1'b0, 32'hFFFFFF40, 32'h0,        3, 32'h000000BF, 5, 1};
    tbl[3] = '{1'b0, 1'b0, 32'h00008000, 32'h0,        0, 32'h00000000, 0, 0};
    tbl[4] = '{1'b0, 1'b1, 32'hFFFFFF83, 32'h0,        1, 32'h7C7D7E7F, 9, 4};
    tbl[5] = '{1'b1, 1'b0, 32'hFFFFFF05, 32'hDEADBEEF, 0, 32'h00000000, 2, 1};
    tbl[6] = '{1'b0, 1'b1, 32'hFFFFFFFC, 32'h0,        0, 32'h00010203, 5, 4};
    tbl[7] = '{1'b1, 1'b1, 32'h7FFFFF00, 32'hCAFEF00D, 0, 32'h00000000, 0, 0};
    tbl[8] = '{1'b0, 1'b0, 32'hFFFFFF12, 32'h0,        2, 32'h00ED0000, 4, 1};

    for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
    mem[8'h13] = 8'hA5;

    reset = 1'b1;
    cpu_addr = 32'h0000_1000; cpu_wdata = 32'h0; cpu_write_en = 1'b0; cpu_wide = 1'b0;
    p_rdata = 8'h00; p_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_cpu_enable", cpu_enable, 1);
    check("reset_cpu_rdata", cpu_rdata, 0);
    check("reset_p_strobe", p_strobe, 0);
    check("reset_p_write_en", p_write_en, 0);
    check("reset_p_addr", p_addr, 0);
    check("reset_p_wdata", p_wdata, 0);
    check("reset_err", err, 0);
    check("reset_state_idle", dbg_state, 0);
    @(negedge clk);
    reset = 1'b0;

    // p_ready while idle must not start anything
    @(negedge clk);
    p_ready = 1'b1; p_rdata = 8'h99;
    cnt = 0; lows = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (p_strobe) cnt++;
      if (!cpu_enable || cpu_rdata != 32'h0) lows++;
      @(negedge clk);
    end
    p_ready = 1'b0;
    check("idle_ready_strobes", cnt, 0);
    check("idle_ready_stall", lows, 0);

    // table vectors
    for (int i = 0; i < 9; i++) begin
      model_access(tbl[i].wr, tbl[i].wide, tbl[i].addr, tbl[i].wdata, tbl[i].delay, m_r, m_s, m_n);
      run_access(tbl[i].wr, tbl[i].wide, tbl[i].addr, tbl[i].wdata, tbl[i].delay, r, s, n, b);
      check($sformatf("tbl%0d_rdata", i), r, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_stall", i), s, tbl[i].exp_stall);
      check($sformatf("tbl%0d_strobes", i), n, tbl[i].exp_nstb);
      check($sformatf("tbl%0d_rdata_outside_done", i), b, 0);
      check($sformatf("tbl%0d_missing_strobes", i), exp_q.size(), 0);
      exp_q.delete();
    end

    // reset after the second strobe of a wide read
    @(negedge clk);
    cpu_addr = 32'hFFFFFF00; cpu_write_en = 1'b0; cpu_wide = 1'b1; p_ready = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10 && cnt < 2; c++) begin
      @(negedge clk);
      #1;
      if (p_strobe) begin
        cnt++;
        p_ready = (cnt == 1);
        p_rdata = 8'h77;
      end else begin
        p_ready = 1'b0;
      end
    end
    check("midreset_strobes_before", cnt, 2);
    p_ready = 1'b0; reset = 1'b1; cpu_addr = 32'h0000_1000;
    @(negedge clk);
    #1;
    check("midreset_cpu_enable", cpu_enable, 1);
    check("midreset_p_strobe", p_strobe, 0);
    check("midreset_err", err, 0);
    check("midreset_cpu_rdata", cpu_rdata, 0);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (p_strobe || cpu_rdata != 32'h0 || !cpu_enable) cnt++;
    end
    check("midreset_quiet_after", cnt, 0);

`ifdef REFLET_BRIDGE_TIMEOUT_EN
    exp_q.push_back({1'b0, 8'h41, 8'h00});
    run_access(1'b0, 1'b0, 32'hFFFFFF41, 32'h0, 1000, r, s, n, b);
    check("timeout_rdata", r, 32'h0000FF00);
    check("timeout_stall", s, 5);
    check("timeout_err", err, 1);
    exp_q.delete();
    model_access(1'b1, 1'b0, 32'hFFFFFF07, 32'hAA000000, 0, m_r, m_s, m_n);
    run_access(1'b1, 1'b0, 32'hFFFFFF07, 32'hAA000000, 0, r, s, n, b);
    check("timeout_err_sticky", err, 1);
    check("timeout_next_stall", s, m_s);
    exp_q.delete();
    do_reset();
    #1;
    check("timeout_err_cleared", err, 0);
`else
    @(negedge clk);
    cpu_addr = 32'hFFFFFF41; cpu_write_en = 1'b0; cpu_wide = 1'b0; p_ready = 1'b0;
    lows = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!cpu_enable) lows++;
      @(negedge clk);
    end
    check("no_timeout_stall", lows, 20);
    check("no_timeout_err", err, 0);
    do_reset();
    #1;
    check("no_timeout_recovered", cpu_enable, 1);
`endif

    // randomized accesses against the model
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      wr     = 1'($urandom_range(0, 1));
      wide   = 1'($urandom_range(0, 1));
      is_hit = ($urandom_range(0, 3) != 0);
      addr   = is_hit ? {24'hFFFFFF, 8'($urandom)} : {8'($urandom_range(0, 254)), 24'($urandom)};
      wdata  = $urandom;
      delay  = $urandom_range(0, 3);
      model_access(wr, wide, addr, wdata, delay, m_r, m_s, m_n);
      run_access(wr, wide, addr, wdata, delay, r, s, n, b);
      check($sformatf("rnd%0d_rdata", i), r, m_r);
      check($sformatf("rnd%0d_stall", i), s, m_s);
      check($sformatf("rnd%0d_strobes", i), n, m_n);
      check($sformatf("rnd%0d_rdata_outside_done", i), b, 0);
      exp_q.delete();
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
